// File: rtl/pw_conv_pkg.sv
// Shared widths and FSM state type for the pointwise convolution engine.
package pw_conv_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int CH_W   = 10;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } pw_state_t;

  // Unsigned activation times signed weight; the zero-extended activation keeps the product exact.
  function automatic logic signed [2*DATA_W:0] mac_product(input logic [DATA_W-1:0] act,
                                                           input logic [DATA_W-1:0] wt);
    return $signed({1'b0, act}) * $signed(wt);
  endfunction

endpackage

// File: rtl/pw_mac_array.sv
// Combinational MAC lanes: sums the products of one load, masking lanes beyond the channel count.
module pw_mac_array
  import pw_conv_pkg::*;
#(
  parameter int NUM_MACS = 16,
  parameter int SUM_W    = 2*DATA_W + 1 + $clog2(NUM_MACS)
) (
  input  logic [0:NUM_MACS-1][DATA_W-1:0] act,
  input  logic [0:NUM_MACS-1][DATA_W-1:0] wt,
  input  logic [CH_W:0]                   in_cnt,
  input  logic [CH_W-1:0]                 num_input_channels,
  output logic signed [SUM_W-1:0]         lane_sum
);

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < NUM_MACS; k++) begin
      if ((32'(in_cnt) + 32'(k)) < 32'(num_input_channels)) begin
        lane_sum = lane_sum + SUM_W'(mac_product(act[k], wt[k]));
      end
    end
  end

endmodule

// File: rtl/pw_conv1x1_engine.sv
// Pointwise (1x1) convolution / dot-product engine: FSM, counters, accumulator, output registers.
// Optional macro PW_CONV_RELU_EN clamps the registered result to >= 0.
module pw_conv1x1_engine
  import pw_conv_pkg::*;
#(
  parameter int NUM_MACS = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CH_W-1:0]                num_input_channels,
  input  logic [CH_W-1:0]                num_output_channels,
  input  logic [0:NUM_MACS-1][DATA_W-1:0] activations,
  input  logic [0:NUM_MACS-1][DATA_W-1:0] weights,
  input  logic                           start_conv,
  input  logic                           clear,
  input  logic                           load_data,
  output logic [ACC_W-1:0]               conv_result,
  output logic                           result_valid,
  output logic                           busy
);

  localparam int           SUM_W = 2*DATA_W + 1 + $clog2(NUM_MACS);
  localparam logic [CH_W:0] STEP = (CH_W+1)'(NUM_MACS);

  pw_state_t               state, next_state;
  logic [CH_W-1:0]         nic_q, noc_q, out_cnt;
  logic [CH_W:0]           in_cnt;
  logic [ACC_W-1:0]        acc, sum_total, result_next;
  logic signed [SUM_W-1:0] lane_sum;
  logic                    start_ok, load_ok, final_load, last_out;

  pw_mac_array #(
    .NUM_MACS(NUM_MACS),
    .SUM_W   (SUM_W)
  ) u_mac_array (
    .act               (activations),
    .wt                (weights),
    .in_cnt            (in_cnt),
    .num_input_channels(nic_q),
    .lane_sum          (lane_sum)
  );

  assign start_ok   = start_conv && (state != ACCUM);
  assign load_ok    = load_data && (state == ACCUM);
  assign final_load = (32'(in_cnt) + 32'(NUM_MACS)) >= 32'(nic_q);
  assign last_out   = (32'(out_cnt) + 32'd1) >= 32'(noc_q);
  assign sum_total  = acc + ACC_W'(lane_sum);
  assign busy       = (state == ACCUM);

`ifdef PW_CONV_RELU_EN
  assign result_next = sum_total[ACC_W-1] ? '0 : sum_total;
`else
  assign result_next = sum_total;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else if (start_ok) begin
      next_state = (num_input_channels == '0) ? DONE : ACCUM;
    end else if (load_ok && final_load && last_out) begin
      next_state = DONE;
    end
  end

  // A zero channel count on start finishes immediately with a zero result.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      acc          <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      nic_q        <= '0;
      noc_q        <= '0;
      conv_result  <= '0;
      result_valid <= 1'b0;
    end else if (start_ok) begin
      acc          <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      nic_q        <= num_input_channels;
      noc_q        <= (num_output_channels == '0) ? CH_W'(1) : num_output_channels;
      result_valid <= (num_input_channels == '0);
      if (num_input_channels == '0) conv_result <= '0;
    end else if (state == ACCUM) begin
      result_valid <= 1'b0;
      if (load_data) begin
        if (final_load) begin
          conv_result  <= result_next;
          result_valid <= 1'b1;
          out_cnt      <= out_cnt + CH_W'(1);
          acc          <= '0;
          in_cnt       <= '0;
        end else begin
          acc    <= sum_total;
          in_cnt <= in_cnt + STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_pw_conv1x1_engine.sv
// Scoreboard bench for pw_conv1x1_engine; expectations follow PW_CONV_RELU_EN when defined.
module tb_pw_conv1x1_engine;

  localparam int NUM_MACS = 16;

  typedef struct {
    int value;
    int due;
  } exp_t;

  logic                           clock = 1'b0;
  logic                           reset = 1'b1;
  logic [9:0]                     num_input_channels = '0;
  logic [9:0]                     num_output_channels = '0;
  logic [0:NUM_MACS-1][7:0]       activations = '0;
  logic [0:NUM_MACS-1][7:0]       weights = '0;
  logic                           start_conv = 1'b0;
  logic                           clear = 1'b0;
  logic                           load_data = 1'b0;
  logic [31:0]                    conv_result;
  logic                           result_valid;
  logic                           busy;

  logic [0:NUM_MACS-1][7:0]       act_next = '0;
  logic [0:NUM_MACS-1][7:0]       wt_next = '0;
  exp_t                           exp_q[$];
  int                             tests_run = 0;
  int                             tests_failed = 0;
  int                             cyc = 0;
  bit                             prev_valid = 1'b0;
  bit                             was_load = 1'b0;
  int                             neg_expect;

  pw_conv1x1_engine #(.NUM_MACS(NUM_MACS)) dut (
    .clock              (clock),
    .reset              (reset),
    .num_input_channels (num_input_channels),
    .num_output_channels(num_output_channels),
    .activations        (activations),
    .weights            (weights),
    .start_conv         (start_conv),
    .clear              (clear),
    .load_data          (load_data),
    .conv_result        (conv_result),
    .result_valid       (result_valid),
    .busy               (busy)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Inputs change only on the falling edge; a pushed expectation is due at the next rising edge.
  task automatic apply_stimulus(input bit st, input bit cl, input bit ld, input bit rs,
                                input bit push = 1'b0, input int val = 0);
    @(negedge clock);
    start_conv  = st;
    clear       = cl;
    load_data   = ld;
    reset       = rs;
    activations = act_next;
    weights     = wt_next;
    if (push) exp_q.push_back('{value: val, due: cyc + 1});
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fill(input int a_base, input int a_step, input int w);
    for (int k = 0; k < NUM_MACS; k++) begin
      act_next[k] = 8'(a_base + a_step * k);
      wt_next[k]  = 8'(w);
    end
  endtask

  // 512 channels of act=k+1, wt=1: 136 per load, 32 loads -> 4352.
  task automatic run_basic(input bit full_checks);
    num_input_channels  = 10'd512;
    num_output_channels = 10'd1;
    fill(1, 1, 1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    if (full_checks) check_output("busy_after_start", int'(busy), 1);
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, (i == 31), 4352);
      idle(2);
    end
    check_output("basic_result", int'($signed(conv_result)), 4352);
    if (full_checks) begin
      check_output("basic_valid_held", int'(result_valid), 1);
      check_output("basic_busy_low", int'(busy), 0);
    end
  endtask

  // Monitor: a new result is a valid rising edge or valid right after a load edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      cyc++;
      was_load = load_data;
      #1;
      if (result_valid === 1'b1 && (was_load || !prev_valid)) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_result: got %0d, expected no result (cycle %0d)",
                   $signed(conv_result), cyc);
        end else begin
          e = exp_q.pop_front();
          check_output("result_value", int'($signed(conv_result)), e.value);
          check_output("result_cycle", cyc, e.due);
        end
      end
      prev_valid = (result_valid === 1'b1);
    end
  end

  initial begin
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    check_output("reset_result", int'(conv_result), 0);
    check_output("reset_valid", int'(result_valid), 0);
    check_output("reset_busy", int'(busy), 0);

    run_basic(1'b1);

    for (int it = 0; it < 64; it++) begin
      run_basic(1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
      idle(1);
      check_output("iter_reset_valid", int'(result_valid), 0);
    end

    // 20 channels, back-to-back loads: second load keeps only lanes 0-3.
    num_input_channels = 10'd20;
    num_output_channels = 10'd1;
    fill(1, 0, 1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 20);
    idle(1);
    check_output("partial_busy_low", int'(busy), 0);

    // 17 channels of ramp data: 136 + lane 0 only (1) = 137.
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    num_input_channels = 10'd17;
    fill(1, 1, 1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 137);
    idle(1);

    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    num_input_channels = 10'd16;
`ifdef PW_CONV_RELU_EN
    neg_expect = 0;
`else
    neg_expect = -160;
`endif
    fill(10, 0, -1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, neg_expect);
    idle(1);
    check_output("signed_result", int'($signed(conv_result)), neg_expect);

    // Three outputs; a start mid-run with zero channels must be ignored.
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    num_input_channels = 10'd16;
    num_output_channels = 10'd3;
    fill(1, 0, 1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16);
    idle(2);
    check_output("multi_pulse_ended", int'(result_valid), 0);
    check_output("multi_busy_mid", int'(busy), 1);
    fill(1, 0, 2);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32);
    num_input_channels = 10'd0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    fill(1, 0, 3);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 48);
    idle(2);
    check_output("multi_busy_low", int'(busy), 0);
    check_output("multi_valid_held", int'(result_valid), 1);
    check_output("multi_final", int'($signed(conv_result)), 48);

    // Abort after 5 loads, then a clean 512-channel run.
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    num_input_channels = 10'd512;
    num_output_channels = 10'd1;
    fill(1, 1, 1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    check_output("clear_busy", int'(busy), 0);
    check_output("clear_valid", int'(result_valid), 0);
    check_output("clear_result", int'(conv_result), 0);
    run_basic(1'b0);

    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    num_input_channels = 10'd0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    idle(1);
    check_output("zero_ch_busy", int'(busy), 0);
    check_output("zero_ch_valid", int'(result_valid), 1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL missing_results: got %0d outstanding, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pw_conv1x1_engine.md
# pw_conv1x1_engine

Implemented module name: `pw_conv1x1_engine`. The block is a 1×1 (pointwise) convolution and fully-connected dot-product engine with `NUM_MACS` parallel 8-bit MAC lanes and a 32-bit accumulator. It sits between the feature-map buffer controller and the activation/requantisation stage. The controller streams input channels `NUM_MACS` at a time, and the engine returns one 32-bit dot product per output channel.

## Interface
- `NUM_MACS`, default 16: parallel MAC lanes (channels consumed per load).
- `clock` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `num_input_channels` in 10: input channels per dot product (0–1023); sampled on `start_conv`.
- `num_output_channels` in 10: dot products per run; sampled on `start_conv`; 0 is treated as 1.
- `activations` in `[0:NUM_MACS-1]` × 8: unsigned activations.
- `weights` in `[0:NUM_MACS-1]` × 8: signed two's-complement weights.
- `start_conv` in 1: single-cycle pulse that begins a run.
- `clear` in 1: single-cycle pulse that aborts, zeroes the accumulator and counters, and returns to IDLE.
- `load_data` in 1: single-cycle pulse; the current lane data is consumed this cycle.
- `conv_result` out 32: signed dot product.
- `result_valid` out 1: `conv_result` holds a finished dot product.
- `busy` out 1: a run is in progress.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- Priority order: `reset` > `clear` > `start_conv` > `load_data`.
- `reset` or `clear`, from any state:
  - go to IDLE;
  - `acc`, `in_cnt`, `out_cnt` = 0;
  - `conv_result` = 0, `result_valid` = 0, `busy` = 0.
- `start_conv` in IDLE or DONE:
  - latch both channel counts;
  - `acc` = 0, `in_cnt` = 0, `out_cnt` = 0, `result_valid` = 0;
  - go to ACCUM, `busy` = 1.
- If the latched `num_input_channels` is 0, the start goes straight to DONE with `conv_result` = 0 and `result_valid` = 1.
- `load_data` in ACCUM, per lane k:
  - product = unsigned act × signed wt (17-bit signed);
  - the product is masked to 0 when `in_cnt`+k ≥ `num_input_channels`;
  - the lane sum is added to `acc` with 32-bit wrap-around;
  - `in_cnt` += `NUM_MACS`.
- A load where `in_cnt`+`NUM_MACS` ≥ `num_input_channels` is the final load of the current output:
  - `conv_result` is registered with `acc` plus the lane sum;
  - `result_valid` = 1;
  - `out_cnt` += 1.
- After a final load, if more outputs remain: `acc` = 0, `in_cnt` = 0, stay in ACCUM, and `result_valid` is a one-cycle pulse.
- After a final load on the last output: go to DONE, `busy` = 0, and `result_valid` and `conv_result` hold until `clear`, `start_conv` or `reset`.
- `load_data` in IDLE or DONE is ignored.
- `start_conv` in ACCUM is ignored.

## Timing
- Reset values: `conv_result` = 0, `result_valid` = 0, `busy` = 0.
- `busy` rises the cycle after the `start_conv` edge.
- Latency: `result_valid` and `conv_result` are visible the cycle after the final `load_data` edge (1 cycle). There is no further pipeline.
- Loads may arrive back-to-back every cycle; idle gaps between loads are allowed and have no effect.
- When `clear` and `start_conv` are asserted in the same cycle, `clear` wins.
- When `clear` arrives mid-run, the partial sum is discarded.

## Configuration
- `PW_CONV_RELU_EN` defined: `conv_result` is clamped to ≥ 0 (a negative final sum is output as 0); the accumulator itself is unclamped.
- `PW_CONV_RELU_EN` undefined: the raw signed 32-bit sum is output.

## Structure
- Shared package `pw_conv_pkg`:
  - `DATA_W` = 8, `ACC_W` = 32, `CH_W` = 10;
  - the `pw_state_t` enum (IDLE, ACCUM, DONE).
- Sub-module `pw_mac_array`: combinational, `NUM_MACS` lanes. Inputs are act, wt, `in_cnt` and `num_input_channels`; output is the masked signed lane sum. A 21-bit sum is sufficient for 16 lanes.
- The top level holds the FSM, counters, accumulator and output registers.

## Test plan
- Basic 512-channel dot product:
  - stimulus: `num_input_channels`=512, `num_output_channels`=1; `clear`, `start_conv`, then 32 loads with act[k]=k+1, wt=1 and 2 idle cycles between loads;
  - response: `result_valid` one cycle after the 32nd load, `conv_result`=4352, `busy`=0.
- Repeated runs with reset between: 64 iterations of the basic scenario with a 1-cycle `reset` after each → every result is 4352 and no iteration hangs.
- Partial final batch: `num_input_channels`=20, act=1, wt=1, 2 loads → `conv_result`=20 (lanes 4–15 of the second load masked).
- Signed weights and ReLU macro: `num_input_channels`=16, act=10, wt=−1 (0xFF) → `conv_result`=−160; with `PW_CONV_RELU_EN` defined → `conv_result`=0.
- Multiple outputs in one run: `num_output_channels`=3, `num_input_channels`=16, one load per output with wt=1,2,3 and act=1 → `result_valid` pulses with 16, 32, then holds 48; `busy` drops after the third.
- Clear mid-run: `clear` after 5 loads, then a restart with 512 channels → `conv_result`=4352 (no residue).
